// File: rtl/hash_response_buffer.sv
// Response buffer behind the hash-table AXI wrapper: first-word-fall-through
// FIFO of raw response words plus saturating per-status event counters.
module hash_response_buffer #(
  parameter int DATA_WIDTH = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_i,
  input  logic [31:0]                   data_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic [31:0]                   data_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  input  logic                          clear_i,
  output logic [CNT_WIDTH-1:0]          ok_cnt_o,
  output logic [CNT_WIDTH-1:0]          nodel_cnt_o,
  output logic [CNT_WIDTH-1:0]          nospace_cnt_o,
  output logic [CNT_WIDTH-1:0]          notfound_cnt_o,
  output logic [CNT_WIDTH-1:0]          dup_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 28) begin : g_bad_data_width
      $error("hash_response_buffer: DATA_WIDTH must be 1..28");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("hash_response_buffer: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [31:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic                 pop;
  logic [4:0]           inc;
  logic [CNT_WIDTH-1:0] cnt [5];

  // Full/empty come from the registered level only, so ready_i never
  // reaches ready_o combinationally and a same-cycle pop cannot unblock a full push.
  assign ready_o = (level != LW'(FIFO_DEPTH));
  assign valid_o = (level != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;
  assign level_o = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; stale contents are hidden while level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  assign inc = {data_i[31], data_i[30], data_i[29], data_i[28], (data_i[31:28] == 4'b0000)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < 5; i++) begin
        if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign ok_cnt_o       = cnt[0];
  assign nodel_cnt_o    = cnt[1];
  assign nospace_cnt_o  = cnt[2];
  assign notfound_cnt_o = cnt[3];
  assign dup_cnt_o      = cnt[4];

endmodule

// File: tb/tb_hash_response_buffer.sv
// Self-checking bench for hash_response_buffer: queue-based reference model,
// directed scenarios plus a randomized mixed-traffic run.
module tb_hash_response_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_i = 1'b0;
  logic [31:0]   data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [31:0]   data_o;
  logic          ready_i = 1'b0;
  logic [3:0]    level_o;
  logic          clear_i = 1'b0;
  logic [CW-1:0] ok_cnt_o, nodel_cnt_o, nospace_cnt_o, notfound_cnt_o, dup_cnt_o;
  logic [CW-1:0] dcnt [5];

  int total  = 0;
  int passed = 0;

  logic [31:0] q [$];
  int          mcnt [5];

  hash_response_buffer #(.DATA_WIDTH(25), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .level_o(level_o),
    .clear_i(clear_i), .ok_cnt_o(ok_cnt_o), .nodel_cnt_o(nodel_cnt_o),
    .nospace_cnt_o(nospace_cnt_o), .notfound_cnt_o(notfound_cnt_o), .dup_cnt_o(dup_cnt_o)
  );

  assign dcnt[0] = ok_cnt_o;
  assign dcnt[1] = nodel_cnt_o;
  assign dcnt[2] = nospace_cnt_o;
  assign dcnt[3] = notfound_cnt_o;
  assign dcnt[4] = dup_cnt_o;

  always #5 clk = ~clk;

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
  endfunction

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit do_push, do_pop;
    logic [31:0] dropped;
    valid_i = v; data_i = d; ready_i = r; clear_i = c;
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    if (do_pop) dropped = q.pop_front();
    if (do_push) q.push_back(d);
    if (c) begin
      for (int i = 0; i < 5; i++) mcnt[i] = 0;
    end else if (do_push) begin
      if (d[31:28] == 4'h0 && mcnt[0] < CMAX) mcnt[0]++;
      for (int b = 0; b < 4; b++)
        if (d[28+b] && mcnt[b+1] < CMAX) mcnt[b+1]++;
    end
    #1;
    valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (valid_o !== 1'b0) $display("FAIL drain_empty valid_o=%0b required 0", valid_o);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #3;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid_o); else passed++;
    total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ready_o); else passed++;
    total++; if (level_o !== 4'd0) $display("FAIL reset_level got=%0d exp=0", level_o); else passed++;
    total++; if (data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", data_o); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (dcnt[i] !== '0) $display("FAIL reset_cnt%0d got=%0d exp=0", i, dcnt[i]); else passed++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(1'b1, 32'h8000_0003, 1'b0, 1'b0);
    total++; if (valid_o !== 1'b1) $display("FAIL first_valid got=%0b exp=1", valid_o); else passed++;
    total++; if (data_o !== 32'h8000_0003) $display("FAIL first_data got=%h exp=80000003", data_o); else passed++;
    total++; if (level_o !== 4'd1) $display("FAIL first_level got=%0d exp=1", level_o); else passed++;
    total++; if (dup_cnt_o !== 4'd1) $display("FAIL first_dup got=%0d exp=1", dup_cnt_o); else passed++;
    total++; if (ok_cnt_o !== 4'd0) $display("FAIL first_ok got=%0d exp=0", ok_cnt_o); else passed++;
  endtask

  task automatic test_fill_full();
    drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 32'(i), 1'b0, 1'b0);
      total++; if (level_o !== 4'(i)) $display("FAIL fill_level got=%0d exp=%0d", level_o, i); else passed++;
    end
    total++; if (ready_o !== 1'b0) $display("FAIL full_ready got=%0b exp=0", ready_o); else passed++;
    total++; if (ok_cnt_o !== 4'd8) $display("FAIL full_ok got=%0d exp=8", ok_cnt_o); else passed++;
    cycle(1'b1, 32'h0000_0009, 1'b0, 1'b0);
    total++; if (level_o !== 4'd8) $display("FAIL ninth_level got=%0d exp=8", level_o); else passed++;
    total++; if (ok_cnt_o !== 4'd8) $display("FAIL ninth_ok got=%0d exp=8", ok_cnt_o); else passed++;
    for (int i = 1; i <= DEPTH; i++) begin
      total++; if (data_o !== 32'(i)) $display("FAIL drain_order got=%h exp=%h", data_o, 32'(i)); else passed++;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    total++; if (valid_o !== 1'b0) $display("FAIL drained_valid got=%0b exp=0", valid_o); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (data_o !== q[0]) $display("FAIL b2b_head got=%h exp=%h", data_o, q[0]); else passed++;
      cycle(1'b1, $urandom, 1'b1, 1'b0);
      total++; if (level_o !== 4'd3) $display("FAIL b2b_level got=%0d exp=3", level_o); else passed++;
    end
    drain();
  endtask

  task automatic test_saturation();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h6000_0000, 1'b1, 1'b0);
    total++; if (nospace_cnt_o !== 4'd15) $display("FAIL sat_nospace got=%0d exp=15", nospace_cnt_o); else passed++;
    total++; if (notfound_cnt_o !== 4'd15) $display("FAIL sat_notfound got=%0d exp=15", notfound_cnt_o); else passed++;
    total++; if (ok_cnt_o !== 4'd0) $display("FAIL sat_ok got=%0d exp=0", ok_cnt_o); else passed++;
    total++; if (nodel_cnt_o !== 4'd0) $display("FAIL sat_nodel got=%0d exp=0", nodel_cnt_o); else passed++;
    total++; if (dup_cnt_o !== 4'd0) $display("FAIL sat_dup got=%0d exp=0", dup_cnt_o); else passed++;
    drain();
  endtask

  task automatic test_clear_priority();
    int lvl;
    cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0);
    total++; if (nodel_cnt_o !== 4'd1) $display("FAIL pre_clear_nodel got=%0d exp=1", nodel_cnt_o); else passed++;
    lvl = q.size();
    cycle(1'b1, 32'h1000_0000, 1'b0, 1'b1);
    total++; if (nodel_cnt_o !== 4'd0) $display("FAIL clear_nodel got=%0d exp=0", nodel_cnt_o); else passed++;
    total++; if (level_o !== 4'(lvl + 1)) $display("FAIL clear_level got=%0d exp=%0d", level_o, lvl + 1); else passed++;
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      total++; if (level_o !== 4'(q.size())) $display("FAIL rnd_level got=%0d exp=%0d", level_o, q.size()); else passed++;
      total++; if (ready_o !== (q.size() < DEPTH)) $display("FAIL rnd_ready got=%0b exp=%0b", ready_o, q.size() < DEPTH); else passed++;
      total++;
      if (data_o !== (q.size() > 0 ? q[0] : 32'h0)) $display("FAIL rnd_data got=%h exp=%h", data_o, q.size() > 0 ? q[0] : 32'h0);
      else passed++;
      for (int i = 0; i < 5; i++) begin
        total++; if (dcnt[i] !== CW'(mcnt[i])) $display("FAIL rnd_cnt%0d got=%0d exp=%0d", i, dcnt[i], mcnt[i]); else passed++;
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, {4'h1, 28'(i)}, 1'b0, 1'b0);
    total++; if (level_o !== 4'd5) $display("FAIL pre_reset_level got=%0d exp=5", level_o); else passed++;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL arst_valid got=%0b exp=0", valid_o); else passed++;
    total++; if (ready_o !== 1'b1) $display("FAIL arst_ready got=%0b exp=1", ready_o); else passed++;
    total++; if (level_o !== 4'd0) $display("FAIL arst_level got=%0d exp=0", level_o); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (dcnt[i] !== '0) $display("FAIL arst_cnt%0d got=%0d exp=0", i, dcnt[i]); else passed++;
    end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 32'h0000_0abc, 1'b0, 1'b0);
    total++; if (data_o !== 32'h0000_0abc) $display("FAIL post_arst_data got=%h exp=00000abc", data_o); else passed++;
    total++; if (ok_cnt_o !== 4'd1) $display("FAIL post_arst_ok got=%0d exp=1", ok_cnt_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_back_to_back();
    test_saturation();
    test_clear_priority();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hash_response_buffer.md
# hash_response_buffer

Response-side stage placed directly downstream of the hash-table AXI wrapper. Accepts the wrapper's 32-bit response words (`read_data` in `[DATA_WIDTH-1:0]`, zero padding, status flags in `[31:28]`) over a valid/ready handshake. Buffers them in a first-word-fall-through FIFO for the consumer (DMA / AXI-Stream master). Keeps saturating per-status event counters for software-visible statistics. Provides the wrapper's `ready_i` backpressure.

## Interface
- `DATA_WIDTH`, 25: width of the read-data field in the response word; must be ≤ 28.
- `FIFO_DEPTH`, 8: number of buffered words; power of two, ≥ 2.
- `CNT_WIDTH`, 16: width of each statistics counter.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `valid_i`  in  1  upstream word valid (wrapper `valid_o`).
- `data_i`  in  32  upstream response word (wrapper `data_o`).
- `ready_o`  out  1  buffer can accept (drives wrapper `ready_i`).
- `valid_o`  out  1  head word available to consumer.
- `data_o`  out  32  head word, passed unmodified.
- `ready_i`  in  1  consumer accepts head word.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `clear_i`  in  1  synchronous clear of all counters.
- `ok_cnt_o`, `nodel_cnt_o`, `nospace_cnt_o`, `notfound_cnt_o`, `dup_cnt_o`  out  CNT_WIDTH each  event counters.

## Operation
- Push when `valid_i && ready_o`; pop when `valid_o && ready_i`. Both may happen in one cycle.
- `ready_o = (level != FIFO_DEPTH)`, combinational from registered level; no combinational path from `ready_i`.
  - A pop in the same cycle does not enable a push while full.
- `valid_o = (level != 0)`. `data_o` = memory[rd_ptr], the oldest unpopped word.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. Level is tracked separately:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither.
- Counters update only on a push (accepted word), from `data_i`:
  - `nodel_cnt` += bit 28
  - `nospace_cnt` += bit 29
  - `notfound_cnt` += bit 30
  - `dup_cnt` += bit 31
  - `ok_cnt` += 1 when bits `[31:28]` are all zero.
  - Several flags set in one word increment each matching counter.
- Counters saturate at all-ones; they never wrap.
- `clear_i` zeroes all counters on the next edge and has priority over a same-cycle increment; that event is lost. `clear_i` does not affect the FIFO.
- Bits `[27:DATA_WIDTH]` are not checked or altered; the word is stored verbatim.

## Timing
- Reset (`reset`=0, asynchronous) takes effect immediately:
  - `rd_ptr`, `wr_ptr`, level = 0
  - `valid_o` = 0, `ready_o` = 1
  - all counters = 0
  - `data_o` = 0; memory contents undefined but masked, since `valid_o` = 0.
- Reset release is synchronous to the next rising edge; the first push is possible on that edge.
- Reset mid-operation discards all buffered words and counts without handshake completion.
- Latency: a word pushed at edge k drives `valid_o`=1 and `data_o` immediately after edge k (1 cycle accept-to-visible).
- Throughput: 1 word/cycle sustained when the consumer holds `ready_i`=1.
- `data_o` and `valid_o` are stable while `valid_o`=1 and `ready_i`=0 (AXI-Stream rule).
- Counters and `level_o` reflect a push or pop from the edge on which it occurs.

## Test plan
- Reset then single push: drive `reset`=0, release, push `32'h8000_0003` with `ready_i`=0. Required after the edge:
  - `valid_o`=1, `data_o`=`32'h8000_0003`, `level_o`=1
  - `dup_cnt_o`=1, `ok_cnt_o`=0.
- Fill and full: push 8 words `0x0000_0001..0x0000_0008` with `ready_i`=0.
  - `ready_o`=0 after the 8th push; `level_o`=8; `ok_cnt_o`=8.
  - A 9th `valid_i` is not accepted.
  - Raising `ready_i` then drains `1..8` in order; `valid_o`=0 afterwards.
- Simultaneous push/pop at level 3, `ready_i`=1, `valid_i`=1 for 10 cycles: `level_o` stays 3; output order is preserved across pointer wrap.
- Multi-flag and saturation with `CNT_WIDTH`=4: push 20 words of `32'h6000_0000`.
  - `nospace_cnt_o` = `notfound_cnt_o` = 15 (saturated).
  - `ok_cnt_o` = `nodel_cnt_o` = `dup_cnt_o` = 0.
- Clear priority: assert `clear_i` in the same cycle as a push of `32'h1000_0000`. Next cycle `nodel_cnt_o`=0 and `level_o` increments by 1.
- Async reset mid-stream: at level 5, pull `reset` low between edges. Immediately `valid_o`=0, `ready_o`=1, `level_o`=0 and all counters 0, with no clock edge required.
